div_share_arbiter: RTL and testbench

//  Shares one integer divider (control unit + datapath) between two requesters.

---
 rtl/div_share_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_div_share_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: shares one integer divider between two requesters.
// Round-robin grant, registered operands, one-cycle div_go, and a one-hot
// response strobe per requester. A zero divisor is answered locally with
// rsp_err=1 and never reaches the divider.
// Optional feature: define DIV_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles; on expiry the divider is aborted and an error returned.
module div_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_err,
  output logic             busy,
  output logic             div_go,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             div_abort
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_gnt_q, last_gnt_d;
  logic [WIDTH-1:0] div_x_q, div_x_d;
  logic [WIDTH-1:0] div_y_q, div_y_d;
  logic [WIDTH-1:0] res_q_q, res_q_d;
  logic [WIDTH-1:0] res_r_q, res_r_d;
  logic             err_q, err_d;
  logic             win;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  // State and datapath registers; last_gnt resets to 1 so req0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      div_x_q    <= '0;
      div_y_q    <= '0;
      res_q_q    <= '0;
      res_r_q    <= '0;
      err_q      <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      div_x_q    <= div_x_d;
      div_y_q    <= div_y_d;
      res_q_q    <= res_q_d;
      res_r_q    <= res_r_d;
      err_q      <= err_d;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
`endif
    end
  end

  // Next-state logic: arbitration in IDLE, capture on the edge leaving a state
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    div_x_d    = div_x_q;
    div_y_d    = div_y_q;
    res_q_d    = res_q_q;
    res_r_d    = res_r_q;
    err_d      = err_q;
    // tie goes to the requester that was not granted last
    win        = (req0 && req1) ? ~last_gnt_q : req1;
`ifdef DIV_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    abort_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sel_d      = win;
          last_gnt_d = win;
          div_x_d    = win ? x1 : x0;
          div_y_d    = win ? y1 : y0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (div_y_q == '0) begin
          // the divider would never signal done on a zero divisor
          res_q_d = '0;
          res_r_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          res_q_d = div_q;
          res_r_d = div_r;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef DIV_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_q_d = '0;
          res_r_d = '0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    busy      = (state_q != S_IDLE);
    div_go    = (state_q == S_ISSUE);
    rsp_valid = 2'b00;
    rsp_q     = '0;
    rsp_r     = '0;
    rsp_err   = 1'b0;
    if (state_q == S_RESP) begin
      rsp_valid = sel_q ? 2'b10 : 2'b01;
      rsp_q     = res_q_q;
      rsp_r     = res_r_q;
      rsp_err   = err_q;
    end
  end

  assign div_x = div_x_q;
  assign div_y = div_y_q;
`ifdef DIV_ARB_TIMEOUT_EN
  assign div_abort = abort_q;
`else
  assign div_abort = 1'b0;
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter; the bench plays both requesters and
// the divider, with hand-computed quotient/remainder values.
module tb_div_share_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [1:0]   rsp_valid;
  logic [W-1:0] rsp_q, rsp_r, div_x, div_y;
  logic         rsp_err, busy, div_go, div_abort;
  logic         div_done = 1'b0;
  logic [W-1:0] div_q = '0, div_r = '0;

  int checks = 0;
  int errors = 0;

  div_share_arbiter #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .busy(busy), .div_go(div_go), .div_x(div_x), .div_y(div_y),
    .div_done(div_done), .div_q(div_q), .div_r(div_r), .div_abort(div_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge where the DUT is in IDLE and the winner's req is up.
  // Ends at the RESP negedge with the winner's req dropped.
  task automatic txn(input int who, input logic [W-1:0] ex, input logic [W-1:0] ey,
                     input logic [W-1:0] dq, input logic [W-1:0] dr,
                     input int wcyc, input bit spur);
    logic [1:0] vexp;
    vexp = (who == 0) ? 2'b01 : 2'b10;
    @(negedge clk);  // GRANT
    chk("g_busy", busy, 1);
    chk("g_x", div_x, ex);
    chk("g_y", div_y, ey);
    chk("g_go", div_go, 0);
    if (who == 0) begin x0 = ~x0; y0 = ~y0; end else begin x1 = ~x1; y1 = ~y1; end
    if (ey == 0) begin
      @(negedge clk);  // RESP
      chk("z_vld", rsp_valid, vexp);
      chk("z_err", rsp_err, 1);
      chk("z_q", rsp_q, 0);
      chk("z_r", rsp_r, 0);
      chk("z_go", div_go, 0);
    end else begin
      @(negedge clk);  // ISSUE
      chk("i_go", div_go, 1);
      chk("i_vld", rsp_valid, 0);
      if (spur) begin div_done = 1'b1; div_q = 4'hf; div_r = 4'hf; end
      @(negedge clk);  // WAIT
      div_done = 1'b0;
      chk("w_go", div_go, 0);
      chk("w_x", div_x, ex);
      chk("w_vld", rsp_valid, 0);
      repeat (wcyc) begin
        @(negedge clk);
        chk("w_hold", {busy, rsp_valid}, 3'b100);
      end
      div_done = 1'b1; div_q = dq; div_r = dr;
      @(negedge clk);  // RESP
      div_done = 1'b0; div_q = '0; div_r = '0;
      chk("r_vld", rsp_valid, vexp);
      chk("r_q", rsp_q, dq);
      chk("r_r", rsp_r, dr);
      chk("r_err", rsp_err, 0);
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    bit seen;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out", {rsp_valid, rsp_q, rsp_r, rsp_err, busy, div_go, div_abort}, 0);
    chk("rst_xy", {div_x, div_y}, 0);
    rst = 1'b0;

    // 13/3 from requester 0
    x0 = 4'd13; y0 = 4'd3; req0 = 1'b1;
    txn(0, 4'd13, 4'd3, 4'd4, 4'd1, 2, 1'b0);
    @(negedge clk);
    chk("t1_idle", {busy, rsp_valid}, 0);

    // 9/0 from requester 1: local error, divider untouched
    x1 = 4'd9; y1 = 4'd0; req1 = 1'b1;
    txn(1, 4'd9, 4'd0, 4'd0, 4'd0, 0, 1'b0);
    @(negedge clk);
    chk("t2_idle", {busy, rsp_valid}, 0);

    // spurious done in IDLE, then in ISSUE
    div_done = 1'b1; div_q = 4'h7; div_r = 4'h7;
    @(negedge clk);
    div_done = 1'b0;
    chk("t6_idle", {busy, rsp_valid, div_go}, 0);
    x0 = 4'd14; y0 = 4'd5; req0 = 1'b1;
    txn(0, 4'd14, 4'd5, 4'd2, 4'd4, 1, 1'b1);
    @(negedge clk);
    chk("t6_end", {busy, rsp_valid}, 0);

    // both requesters high out of reset
    rst = 1'b1;
    x0 = 4'd15; y0 = 4'd4; x1 = 4'd7; y1 = 4'd2; req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txn(0, 4'd15, 4'd4, 4'd3, 4'd3, 0, 1'b0);
    @(negedge clk);
    chk("t3_gap", busy, 0);
    txn(1, 4'd7, 4'd2, 4'd3, 4'd1, 1, 1'b0);
    x0 = 4'd6; y0 = 4'd4; req0 = 1'b1;
    @(negedge clk);
    txn(0, 4'd6, 4'd4, 4'd1, 4'd2, 0, 1'b0);
    @(negedge clk);
    // tie with last grant = 0: requester 1 first, then 0
    x0 = 4'd5; y0 = 4'd5; x1 = 4'd11; y1 = 4'd3; req0 = 1'b1; req1 = 1'b1;
    txn(1, 4'd11, 4'd3, 4'd3, 4'd2, 0, 1'b0);
    @(negedge clk);
    txn(0, 4'd5, 4'd5, 4'd1, 4'd0, 0, 1'b0);
    @(negedge clk);
    chk("t3_end", {busy, rsp_valid}, 0);

    // reset while waiting on the divider
    x0 = 4'd5; y0 = 4'd1; req0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_wait", {busy, div_go}, 2'b10);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("t4_rst", {busy, rsp_valid, div_go}, 0);
    chk("t4_xy", {div_x, div_y}, 0);
    rst = 1'b0;
    x0 = 4'd8; y0 = 4'd2; req0 = 1'b1;
    txn(0, 4'd8, 4'd2, 4'd4, 4'd0, 3, 1'b0);
    @(negedge clk);
    chk("t4_end", {busy, rsp_valid}, 0);

    // divider never answers
    x0 = 4'd9; y0 = 4'd2; req0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_go", div_go, 1);
`ifdef DIV_ARB_TIMEOUT_EN
    repeat (8) begin
      @(negedge clk);
      chk("t5_wait", {rsp_valid, div_abort, busy}, 4'b0001);
    end
    @(negedge clk);
    chk("t5_abort", div_abort, 1);
    chk("t5_err", {rsp_valid, rsp_err, rsp_q, rsp_r}, {2'b01, 1'b1, 8'h00});
    req0 = 1'b0;
    @(negedge clk);
    chk("t5_idle", {busy, div_abort}, 0);
`else
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || div_abort) seen = 1'b1;
    end
    chk("t5_norsp", seen, 0);
    chk("t5_busy", busy, 1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
